// File: rtl/div_seq.sv
// Multi-cycle 32-bit restoring divider for the EX stage; result is {remainder, quotient}.
// Signed divide (DIV) support is built only when DIV_SIGNED_EN is defined; otherwise all divides are unsigned.
module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  localparam int unsigned REG_W   = 32;
  localparam int unsigned DREG_W  = 64;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned LAST_IT = 31;

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [REG_W-1:0]    r_rem;
  logic [REG_W-1:0]    r_quo;
  logic [REG_W-1:0]    r_dvs;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_neg_q;
  logic                r_neg_r;
  logic [DREG_W-1:0]   r_result;
  logic                r_ready;
  logic                w_stall;

  logic [REG_W:0]      w_part;
  logic [REG_W+1:0]    w_trial;
  logic                w_qbit;
  logic [REG_W-1:0]    w_rem_nxt;
  logic [REG_W-1:0]    w_quo_nxt;
  logic                w_neg1;
  logic                w_neg2;
  logic [REG_W-1:0]    w_mag1;
  logic [REG_W-1:0]    w_mag2;
  logic [REG_W-1:0]    w_fix_q;
  logic [REG_W-1:0]    w_fix_r;
  logic                w_last;

  // One restoring step: shift in the next dividend bit and try to subtract the divisor.
  assign w_part    = {r_rem, r_quo[REG_W-1]};
  assign w_trial   = {1'b0, w_part} - {2'b00, r_dvs};
  assign w_qbit    = ~w_trial[REG_W+1];
  assign w_rem_nxt = w_qbit ? REG_W'(w_trial) : REG_W'(w_part);
  assign w_quo_nxt = {r_quo[REG_W-2:0], w_qbit};
  assign w_last    = (r_cnt == CNT_W'(LAST_IT));

`ifdef DIV_SIGNED_EN
  always_comb begin
    w_neg1  = signed_div_i & opdata1_i[REG_W-1];
    w_neg2  = signed_div_i & opdata2_i[REG_W-1];
    w_mag1  = w_neg1 ? (~opdata1_i + REG_W'(1)) : opdata1_i;
    w_mag2  = w_neg2 ? (~opdata2_i + REG_W'(1)) : opdata2_i;
    w_fix_q = r_neg_q ? (~w_quo_nxt + REG_W'(1)) : w_quo_nxt;
    w_fix_r = r_neg_r ? (~w_rem_nxt + REG_W'(1)) : w_rem_nxt;
  end
`else
  logic w_unused_sign;
  assign w_unused_sign = ^{signed_div_i, r_neg_q, r_neg_r};

  always_comb begin
    w_neg1  = 1'b0;
    w_neg2  = 1'b0;
    w_mag1  = opdata1_i;
    w_mag2  = opdata2_i;
    w_fix_q = w_quo_nxt;
    w_fix_r = w_rem_nxt;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FREE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      S_FREE: begin
        if (start_i && !annul_i) begin
          w_stall     = 1'b1;
          w_state_nxt = (opdata2_i == '0) ? S_BYZERO : S_ON;
        end
      end
      S_BYZERO: begin
        w_stall     = 1'b1;
        w_state_nxt = annul_i ? S_FREE : S_END;
      end
      S_ON: begin
        w_stall = 1'b1;
        if (annul_i)     w_state_nxt = S_FREE;
        else if (w_last) w_state_nxt = S_END;
      end
      S_END: begin
        if (!start_i) w_state_nxt = S_FREE;
      end
      default: w_state_nxt = S_FREE;
    endcase
  end

  // Working registers, iteration counter and the registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
        S_FREE: begin
          r_result <= '0;
          r_ready  <= 1'b0;
          if (w_state_nxt == S_ON) begin
            r_rem   <= '0;
            r_quo   <= w_mag1;
            r_dvs   <= w_mag2;
            r_cnt   <= '0;
            r_neg_q <= w_neg1 ^ w_neg2;
            r_neg_r <= w_neg1;
          end
        end
        S_BYZERO: begin
          r_rem <= '0;
          r_quo <= '0;
          if (w_state_nxt == S_END) begin
            r_result <= '0;
            r_ready  <= 1'b1;
          end
        end
        S_ON: begin
          if (annul_i) begin
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= '0;
          end else begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_result <= {w_fix_r, w_fix_q};
              r_ready  <= 1'b1;
            end
          end
        end
        S_END: begin
          if (!start_i) begin
            r_result <= '0;
            r_ready  <= 1'b0;
          end
        end
        default: begin
          r_result <= '0;
          r_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign result_o   = r_result;
  assign ready_o    = r_ready;
  // Stall is combinational so EX freezes in the start cycle; reset forces it low at once.
  assign stallreq_o = w_stall & ~rst;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: cycle-level reference model plus directed vectors.
// Expected literals follow DIV_SIGNED_EN the same way the design does.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div = 1'b0;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic [31:0] op1 = 32'h0;
  logic [31:0] op2 = 32'h0;
  logic [63:0] result;
  logic        ready;
  logic        stall;

  int checks = 0;
  int errors = 0;

  div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .stallreq_o   (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Architectural result from plain arithmetic (truncating division, 32-bit modulo).
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint qa, qb, q, r;
    logic   eff;
`ifdef DIV_SIGNED_EN
    eff = s;
`else
    eff = s & 1'b0;
`endif
    if (b == 32'h0) return 64'h0;
    if (eff) begin
      qa = longint'($signed(a));
      qb = longint'($signed(b));
    end else begin
      qa = longint'({32'h0, a});
      qb = longint'({32'h0, b});
    end
    q = qa / qb;
    r = qa % qb;
    return {r[31:0], q[31:0]};
  endfunction

  // Transaction-level model: idle / busy for a fixed number of edges / done.
  typedef enum int {M_IDLE, M_BUSY, M_DONE} mph_t;
  mph_t        m_ph   = M_IDLE;
  int          m_left = 0;
  logic [63:0] m_res  = 64'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph   <= M_IDLE;
      m_left <= 0;
      m_res  <= 64'h0;
    end else begin
      case (m_ph)
        M_IDLE: if (start && !annul) begin
          m_res  <= ref_div(signed_div, op1, op2);
          m_left <= (op2 == 32'h0) ? 1 : 32;
          m_ph   <= M_BUSY;
        end
        M_BUSY: begin
          if (annul)            m_ph <= M_IDLE;
          else if (m_left == 1) m_ph <= M_DONE;
          else                  m_left <= m_left - 1;
        end
        default: if (!start) m_ph <= M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    logic exp_stall;
    exp_stall = !rst && ((m_ph == M_BUSY) || (m_ph == M_IDLE && start && !annul));
    chk("cyc_ready",  64'(ready),  64'(m_ph == M_DONE));
    chk("cyc_stall",  64'(stall),  64'(exp_stall));
    chk("cyc_result", result, (m_ph == M_DONE) ? m_res : 64'h0);
  end

  task automatic run_div(input string name, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    int n = 0;
    int stalls = 0;
    bit got = 1'b0;
    @(posedge clk); #1;
    signed_div = s; op1 = a; op2 = b; start = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (ready) got = 1'b1;
      else begin
        n++;
        if (stall) stalls++;
      end
    end
    chk({name, "_lat"},    64'(n),      64'(exp_lat));
    chk({name, "_stalls"}, 64'(stalls), 64'(exp_lat));
    chk({name, "_res"},    result,      exp);
    chk({name, "_stallend"}, 64'(stall), 64'h0);
    @(negedge clk);
    chk({name, "_hold"},   64'(ready),  64'h1);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk({name, "_drop_rdy"}, 64'(ready), 64'h0);
    chk({name, "_drop_res"}, result,     64'h0);
  endtask

  initial begin
    int seen;
    logic [63:0] exp_m7_2, exp_min_m1, exp_7_m2;
`ifdef DIV_SIGNED_EN
    exp_m7_2   = 64'hFFFFFFFF_FFFFFFFD;
    exp_min_m1 = 64'h00000000_80000000;
    exp_7_m2   = 64'h00000001_FFFFFFFD;
`else
    exp_m7_2   = 64'h00000001_7FFFFFFC;
    exp_min_m1 = 64'h80000000_00000000;
    exp_7_m2   = 64'h00000007_00000000;
`endif

    repeat (2) @(negedge clk);
    chk("rst_ready",  64'(ready), 64'h0);
    chk("rst_result", result,     64'h0);
    chk("rst_stall",  64'(stall), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_div("u100_7",   1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 33);
    run_div("s_m7_2",   1'b1, 32'hFFFFFFF9,   32'd2,        exp_m7_2,              33);
    run_div("z5_0",     1'b0, 32'd5,          32'd0,        64'h0,                 2);
    run_div("smin_m1",  1'b1, 32'h80000000,   32'hFFFFFFFF, exp_min_m1,            33);
    run_div("s7_m2",    1'b1, 32'd7,          32'hFFFFFFFE, exp_7_m2,              33);
    run_div("uffff_1",  1'b0, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF, 33);
    run_div("u7_100",   1'b0, 32'd7,          32'd100,      64'h00000007_00000000, 33);

    // Annul after ten iterations.
    @(posedge clk); #1;
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    annul = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("annul_busy", 64'(stall), 64'h1);
    @(posedge clk); #1;
    annul = 1'b0;
    @(negedge clk);
    chk("annul_stall", 64'(stall), 64'h0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) seen++;
    end
    chk("annul_noready", 64'(seen), 64'h0);
    run_div("u9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

    // Asynchronous reset in the middle of a divide.
    @(posedge clk); #1;
    op1 = 32'd12345; op2 = 32'd17; start = 1'b1;
    repeat (21) @(posedge clk);
    #3;
    chk("prerst_stall", 64'(stall), 64'h1);
    rst = 1'b1;
    #1;
    chk("midrst_ready",  64'(ready), 64'h0);
    chk("midrst_result", result,     64'h0);
    chk("midrst_stall",  64'(stall), 64'h0);
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_div("u12345_17", 1'b0, 32'd12345, 32'd17, 64'h00000003_000002D6, 33);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle 32-bit divide sequencer for the EX stage. It takes operands from the ID/EX path, runs a one-bit-per-cycle restoring division under a four-state FSM, and holds EX with a stall request until the 64-bit {remainder, quotient} result is ready. EX then routes `result_o` to HI/LO. EX and the pipeline stall controller are the only clients.

## Interface
Parameters: none. Widths come from the shared defines: RegBus is 32 bits, DoubleRegBus is 64 bits.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset (`RstEnable` = 1). One clock; reset is asynchronous and active-high.
- `signed_div_i` input 1: 1 selects a signed divide (DIV), 0 selects unsigned (DIVU).
- `opdata1_i` input 32: dividend.
- `opdata2_i` input 32: divisor.
- `start_i` input 1: request a divide. Level-held by EX until the result is consumed.
- `annul_i` input 1: cancel. Driven by a flush or an exception.
- `result_o` output 64: result as {remainder[63:32], quotient[31:0]}.
- `ready_o` output 1: `result_o` is valid.
- `stallreq_o` output 1: stall request to the pipeline controller.

## Operation
- FSM states: FREE, BYZERO, ON, END. Reset state is FREE.
- Reset values: `result_o` = `ZeroWord` pair (64'h0), `ready_o` = 0, iteration counter = 0.
- FREE:
  - `start_i`=1 and `annul_i`=0 with divisor 0: go to BYZERO.
  - `start_i`=1 and `annul_i`=0 with divisor nonzero: latch operands, clear counter, go to ON.
  - Otherwise stay in FREE with `ready_o`=0 and `result_o`=0.
- Operand latch on a signed divide: replace each negative operand by its two's-complement magnitude before latching.
- BYZERO: the working register becomes 0, then go to END.
- ON: one iteration per cycle.
  - Compute a 33-bit trial: {1'b0, partial_rem} − {1'b0, divisor}.
  - If the trial is non-negative, shift in quotient bit 1 and keep the difference.
  - Otherwise shift in 0 and keep the partial remainder.
  - Counter increments 0..31. On the edge that completes iteration 31, go to END.
- Sign fix-up, applied on the transition into END for signed divides:
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend was negative.
- Arithmetic rules:
  - All values are 32-bit modulo.
  - -2^31 / -1 gives quotient 0x80000000 and remainder 0. No trap.
- END:
  - `ready_o`=1; `result_o` holds the final value.
  - Stay in END while `start_i`=1; go to FREE when `start_i`=0.
  - On the FREE transition, `ready_o` drops and `result_o` clears.
- Divide by zero: END with `result_o`=0. The architecture leaves the value unpredictable; the team has fixed it at 0.
- Annul:
  - `annul_i`=1 in ON or BYZERO: go to FREE on the next edge and discard partial state.
  - `annul_i`=1 in FREE blocks a start.
  - `annul_i` is ignored in END.
- Operand changes while in ON are ignored; the latched copies are used.
- `stallreq_o` is combinational:
  - 1 in FREE when `start_i` & ~`annul_i`.
  - 1 in BYZERO and ON.
  - 0 in END and in idle FREE.

## Timing
- Edge E0 samples `start_i`. Iterations run on E1..E32. END is entered at E32, so `ready_o` is high in the cycle after E32.
- Total latency: 33 edges including E0.
- Divide by zero: BYZERO at E0, END at E1. `ready_o` is high after E1 (2 edges).
- `stallreq_o` is high in the start cycle itself, so EX freezes the same cycle.
- It falls in the first cycle of END, letting the pipeline advance with the result.
- Reset mid-operation: FREE asynchronously. All outputs return to reset values immediately, without waiting for a clock edge.
- Back-to-back divides: FREE must be visited for at least one cycle (`start_i`=0) between requests.

## Configuration
- Macro: `DIV_SIGNED_EN`.
- Defined:
  - `signed_div_i` is honoured.
  - Operand magnitude conversion and result sign fix-up are built.
- Undefined:
  - `signed_div_i` is ignored; every divide is unsigned.
  - Negation logic is not synthesized.
  - Latency is unchanged.

## Test plan
- Unsigned 100 / 7, `start_i` held:
  - `stallreq_o`=1 for 33 cycles, then `ready_o`=1.
  - `result_o` = 64'h00000002_0000000E.
- Signed -7 / 2 (opdata1 = 0xFFFFFFF9):
  - `result_o` = 64'hFFFFFFFF_FFFFFFFD.
  - With `DIV_SIGNED_EN` undefined: 64'h00000001_7FFFFFFC.
- 5 / 0:
  - `ready_o`=1 after 2 edges, `result_o`=0.
  - Drop `start_i`: state returns to FREE and `ready_o`=0.
- Signed 0x80000000 / 0xFFFFFFFF: `result_o` = 64'h00000000_80000000.
- Annul during ON:
  - Assert `annul_i` at iteration 10.
  - Next edge: FREE, `stallreq_o`=0, `ready_o` never rises.
  - A fresh 9 / 3 afterwards returns 64'h00000000_00000003.
- Reset mid-operation:
  - Assert `rst` at iteration 20, between edges.
  - Outputs go to 0 immediately.
  - After release, a new divide completes with full 33-edge latency.
